// File: rtl/seq_det_pkg.sv
// Shared state encodings and width helper for the serial sequence detector.
// Imported by seq_shift_window and seq_pattern_detector.
package seq_det_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_SCAN = 2'b01;
   localparam state_t ST_LOCK = 2'b11;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/seq_shift_window.sv
// Serial window shift register with a saturating fill counter.
// Stores the PAT_W-1 most recent valid bits; the live bit completes the window.
module seq_shift_window
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             X,
   input  logic             flush,
   output logic [PAT_W-2:0] win,
   output logic             full_m1
);

   localparam int unsigned FillW = cnt_w(PAT_W);

   logic [PAT_W-2:0] win_q, win_d;
   logic [FillW-1:0] fill_q, fill_d;

   always_comb begin
      win_d  = win_q;
      fill_d = fill_q;
      if (flush) begin
         win_d  = '0;
         fill_d = '0;
      end else if (EN) begin
         win_d = (PAT_W-1)'({win_q, X});
         if (fill_q != FillW'(PAT_W)) begin
            fill_d = fill_q + FillW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
      end
   end

   assign win     = win_q;
   assign full_m1 = (fill_q >= FillW'(PAT_W - 1));

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: match counter, sticky lock and match/lock flags.
// Define SEQ_DET_GAP_RESET_EN to clear the match count after GAP_MAX valid bits without a hit.
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W    = 4,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned GAP_MAX  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             X,
   input  logic             EN,
   input  logic [PAT_W-1:0] PATTERN,
   input  logic             OVERLAP,
   input  logic             CLR,
   output logic             MATCH,
   output logic             LOCKED,
   output logic [CNT_W-1:0] MATCH_CNT,
   output logic             Y
);

   if (PAT_W < 2 || LOCK_CNT < 1 || LOCK_CNT > (1 << CNT_W) - 1 || GAP_MAX < 1)
   begin : g_param_check
      $error("seq_pattern_detector: illegal parameter combination");
   end

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W:0]   LockAt = (CNT_W+1)'(LOCK_CNT);

   state_t           state_q, state_d;
   logic             match_q, match_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;

   logic [PAT_W-2:0] win;
   logic             full_m1;
   logic             shift_en;
   logic             hit;
   logic             lock_now;
   logic             flush;

`ifdef SEQ_DET_GAP_RESET_EN
   localparam int unsigned GapW   = cnt_w(GAP_MAX);
   localparam logic [GapW-1:0] GapMax = GapW'(GAP_MAX);

   logic [GapW-1:0] gap_q, gap_d;
   logic [GapW-1:0] gap_inc;

   assign gap_inc = gap_q + GapW'(1);
`endif

   // The window is frozen while locked so X cannot leak through.
   assign shift_en = EN & (state_q != ST_LOCK);
   assign hit      = shift_en & full_m1 & ({win, X} == PATTERN);
   assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign lock_now = (cnt_inc == LockAt);
   assign flush    = CLR | (hit & ~OVERLAP);

   seq_shift_window #(
      .PAT_W (PAT_W)
   ) u_window (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (shift_en),
      .X       (X),
      .flush   (flush),
      .win     (win),
      .full_m1 (full_m1)
   );

   always_comb begin
      state_d  = state_q;
      match_d  = 1'b0;
      locked_d = locked_q;
      cnt_d    = cnt_q;
`ifdef SEQ_DET_GAP_RESET_EN
      gap_d    = gap_q;
`endif
      if (CLR) begin
         state_d  = ST_IDLE;
         locked_d = 1'b0;
         cnt_d    = '0;
`ifdef SEQ_DET_GAP_RESET_EN
         gap_d    = '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE, ST_SCAN: begin
               if (state_q == ST_IDLE && full_m1) begin
                  state_d = ST_SCAN;
               end
               if (hit) begin
                  match_d = 1'b1;
                  if (cnt_q != CntMax) begin
                     cnt_d = cnt_inc[CNT_W-1:0];
                  end
                  if (lock_now) begin
                     state_d  = ST_LOCK;
                     locked_d = 1'b1;
                  end
`ifdef SEQ_DET_GAP_RESET_EN
                  gap_d = '0;
`endif
               end
`ifdef SEQ_DET_GAP_RESET_EN
               else if (shift_en && state_q == ST_SCAN) begin
                  if (gap_inc == GapMax) begin
                     gap_d = '0;
                     cnt_d = '0;
                  end else begin
                     gap_d = gap_inc;
                  end
               end
`endif
            end
            ST_LOCK: begin
               state_d = ST_LOCK;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         match_q  <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef SEQ_DET_GAP_RESET_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`endif

   assign MATCH     = match_q;
   assign LOCKED    = locked_q;
   assign MATCH_CNT = cnt_q;
   assign Y         = match_q | locked_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector (PAT_W=4, PATTERN=1011, LOCK_CNT=2, GAP_MAX=8).
module tb_seq_pattern_detector;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       X = 1'b0;
   logic       EN = 1'b0;
   logic [3:0] PATTERN = 4'b1011;
   logic       OVERLAP = 1'b1;
   logic       CLR = 1'b0;
   logic       MATCH;
   logic       LOCKED;
   logic [3:0] MATCH_CNT;
   logic       Y;

   int checks = 0;
   int failures = 0;

   // Expected entry: {match, locked, match_cnt[3:0]}
   logic [5:0] sb[$];

   seq_pattern_detector #(
      .PAT_W    (4),
      .CNT_W    (4),
      .LOCK_CNT (2),
      .GAP_MAX  (8)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .X         (X),
      .EN        (EN),
      .PATTERN   (PATTERN),
      .OVERLAP   (OVERLAP),
      .CLR       (CLR),
      .MATCH     (MATCH),
      .LOCKED    (LOCKED),
      .MATCH_CNT (MATCH_CNT),
      .Y         (Y)
   );

   always #5 CLK = ~CLK;

   function automatic logic [5:0] ev(input int m, input int l, input int c);
      return {m[0], l[0], c[3:0]};
   endfunction

   function automatic logic [6:0] obs();
      return {MATCH, LOCKED, MATCH_CNT, Y};
   endfunction

   task automatic step(input logic x, input logic en, input logic clr);
      @(negedge CLK);
      X   = x;
      EN  = en;
      CLR = clr;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (obs() !== 7'b0) begin
         failures++;
         $display("FAIL reset got=%b required=%b", obs(), 7'b0);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_basic();
      logic [4:0] xs = 5'b10110;
      logic [4:0] es = 5'b11110;
      logic [5:0] ex [5] = '{ev(0,0,0), ev(0,0,0), ev(0,0,0), ev(1,0,1), ev(0,0,1)};
      logic [5:0] e;
      OVERLAP = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb.push_back(ex[i]);
         step(xs[4-i], es[4-i], 1'b0);
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL basic step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   task automatic test_non_overlap();
      logic [7:0] xs = 8'b01011011;
      logic [7:0] cs = 8'b10000000;
      logic [5:0] ex [8] = '{ev(0,0,0), ev(0,0,0), ev(0,0,0), ev(0,0,0),
                             ev(1,0,1), ev(0,0,1), ev(0,0,1), ev(0,0,1)};
      logic [5:0] e;
      OVERLAP = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sb.push_back(ex[i]);
         step(xs[7-i], ~cs[7-i], cs[7-i]);
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL non_overlap step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   task automatic test_overlap_lock();
      logic [8:0] xs = 9'b010110110;
      logic [8:0] es = 9'b011111110;
      logic [8:0] cs = 9'b100000000;
      logic [5:0] ex [9] = '{ev(0,0,0), ev(0,0,0), ev(0,0,0), ev(0,0,0), ev(1,0,1),
                             ev(0,0,1), ev(0,0,1), ev(1,1,2), ev(0,1,2)};
      logic [5:0] e;
      OVERLAP = 1'b1;
      for (int i = 0; i < 9; i++) begin
         sb.push_back(ex[i]);
         step(xs[8-i], es[8-i], cs[8-i]);
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL overlap_lock step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   task automatic test_lock_hold();
      logic       x;
      logic [5:0] e;
      for (int i = 0; i < 11; i++) begin
         x = 1'($urandom_range(0, 1));
         sb.push_back((i < 10) ? ev(0,1,2) : ev(0,0,0));
         step(x, (i < 10), (i == 10));
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL lock_hold step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   task automatic test_en_gating();
      logic [6:0] xs = 7'b1011011;
      logic [6:0] es = 7'b1001111;
      logic [5:0] ex [7] = '{ev(0,0,0), ev(0,0,0), ev(0,0,0), ev(0,0,0),
                             ev(0,0,0), ev(0,0,0), ev(1,0,1)};
      logic [5:0] e;
      OVERLAP = 1'b1;
      for (int i = 0; i < 7; i++) begin
         sb.push_back(ex[i]);
         step(xs[6-i], es[6-i], 1'b0);
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL en_gating step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] xs = 7'b1011011;
      logic [5:0] ex [7] = '{ev(0,0,1), ev(0,0,1), ev(0,0,1),
                             ev(0,0,0), ev(0,0,0), ev(0,0,0), ev(1,0,1)};
      logic [5:0] e;
      for (int i = 0; i < 7; i++) begin
         if (i == 3) begin
            #2;
            RST = 1'b1;
            #1;
            checks++;
            if (obs() !== 7'b0) begin
               failures++;
               $display("FAIL reset_mid_async got=%b required=%b", obs(), 7'b0);
            end
            @(negedge CLK);
            RST = 1'b0;
         end
         sb.push_back(ex[i]);
         step(xs[6-i], 1'b1, 1'b0);
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL reset_mid step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   task automatic test_gap();
      logic [16:0] xs = 17'b01011000000001011;
      logic [5:0]  ex [17];
      logic [5:0]  e;
      ex[0] = ev(0,0,0);
      for (int i = 1; i < 4; i++) ex[i] = ev(0,0,0);
      ex[4] = ev(1,0,1);
      for (int i = 5; i < 12; i++) ex[i] = ev(0,0,1);
`ifdef SEQ_DET_GAP_RESET_EN
      ex[12] = ev(0,0,0);
      for (int i = 13; i < 16; i++) ex[i] = ev(0,0,0);
      ex[16] = ev(1,0,1);
`else
      ex[12] = ev(0,0,1);
      for (int i = 13; i < 16; i++) ex[i] = ev(0,0,1);
      ex[16] = ev(1,1,2);
`endif
      OVERLAP = 1'b0;
      for (int i = 0; i < 17; i++) begin
         sb.push_back(ex[i]);
         step(xs[16-i], (i != 0), (i == 0));
         e = sb.pop_front();
         checks++;
         if (obs() !== {e, e[5] | e[4]}) begin
            failures++;
            $display("FAIL gap step %0d got=%b required=%b", i, obs(), {e, e[5] | e[4]});
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_non_overlap();
      test_overlap_lock();
      test_lock_hold();
      test_en_gating();
      test_reset_mid();
      test_gap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
